alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational ALU. It executes the same nine-opcode instruction set on WIDTH-bit operands and holds a persistent NZCV flag register, so carry-in to ADCS/SBCS is architecturally defined. Multiplication is iterative shift-add instead of a full array. The block sits between the operand-fetch stage and the writeback stage, using valid/ready on both sides.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch and writeback for alu_seq.
// The master side feeds operands and drains results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, negative, zero, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, negative, zero, carry, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential nine-opcode ALU with a persistent NZCV register and an iterative
// shift-add multiplier; one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  localparam logic [3:0] OpAdcs = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSbcs = 4'd2;
  localparam logic [3:0] OpSubs = 4'd3;
  localparam logic [3:0] OpRsbs = 4'd4;
  localparam logic [3:0] OpMuls = 4'd5;
  localparam logic [3:0] OpAnds = 4'd6;
  localparam logic [3:0] OpOrrs = 4'd7;
  localparam logic [3:0] OpCmp  = 4'd8;

  localparam logic [WIDTH-1:0] MulLast = WIDTH'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             n_q, z_q, c_q, v_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, prod_q, cnt_q;

  logic             accept;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] result_d;
  logic             set_nz_d, set_cv_d, c_d, v_d;
  logic [WIDTH-1:0] prod_d;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.negative  = n_q;
  assign bus.zero      = z_q;
  assign bus.carry     = c_q;
  assign bus.overflow  = v_q;

  // One shared adder: subtraction forms are x + ~y + cin.
  always_comb begin
    add_x    = bus.a;
    add_y    = bus.b;
    add_cin  = 1'b0;
    result_d = '0;
    set_nz_d = 1'b0;
    set_cv_d = 1'b0;
    case (bus.opcode)
      OpAdcs: add_cin = c_q;
      OpSbcs: begin
        add_y   = ~bus.b;
        add_cin = c_q;
      end
      OpSubs, OpCmp: begin
        add_y   = ~bus.b;
        add_cin = 1'b1;
      end
      OpRsbs: begin
        add_x   = bus.b;
        add_y   = ~bus.a;
        add_cin = 1'b1;
      end
      default: ;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    c_d     = add_sum[WIDTH];
    v_d     = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    case (bus.opcode)
      OpAdcs, OpSbcs, OpSubs, OpRsbs, OpCmp: begin
        result_d = add_sum[WIDTH-1:0];
        set_nz_d = 1'b1;
        set_cv_d = 1'b1;
      end
      OpAdd: result_d = add_sum[WIDTH-1:0];
      OpAnds: begin
        result_d = bus.a & bus.b;
        set_nz_d = 1'b1;
      end
      OpOrrs: begin
        result_d = bus.a | bus.b;
        set_nz_d = 1'b1;
      end
      default: result_d = '0;
    endcase
    prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // The last multiply step writes its own sum so the result lands WIDTH edges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.opcode == OpMuls) begin
              mcand_q  <= bus.a;
              mplier_q <= bus.b;
              prod_q   <= '0;
              cnt_q    <= '0;
              state_q  <= MUL;
            end else begin
              result_q <= result_d;
              if (set_nz_d) begin
                n_q <= result_d[WIDTH-1];
                z_q <= (result_d == '0);
              end
              if (set_cv_d) begin
                c_q <= c_d;
                v_q <= v_d;
              end
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        MUL: begin
          if (cnt_q == MulLast) begin
            result_q    <= prod_d;
            n_q         <= prod_d[WIDTH-1];
            z_q         <= (prod_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: table of ops with hand-derived results and
// flags, scoreboard queue of expectations, plus backpressure and mid-MUL reset.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  nzcv;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  nzcv;
    int          lat;
    int          acceptCyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[19];

  wire [3:0] nzcv = {bus.negative, bus.zero, bus.carry, bus.overflow};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Present an op, wait (bounded) for acceptance, and queue its expected outcome.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic [3:0] fl, input int lat);
    int   waitCyc;
    logic rdy;
    exp_t e;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    waitCyc = 0;
    rdy     = 1'b0;
    while (!rdy && waitCyc < 50) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      waitCyc++;
    end
    bus.in_valid = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no in_ready want in_ready within 50 cycles");
    end else begin
      e.res       = res;
      e.nzcv      = fl;
      e.lat       = lat;
      e.acceptCyc = cyc;
      sb.push_back(e);
    end
  endtask

  // Wait for out_valid, compare against the queue head, optionally stall, then drain.
  task automatic checkOutput(input int hold);
    int   waitCyc;
    exp_t e;
    waitCyc = 0;
    while (!bus.out_valid && waitCyc < 100) begin
      @(posedge clk);
      #1;
      waitCyc++;
    end
    if (!bus.out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL out_timeout: got out_valid=0 want out_valid=1 within 100 cycles");
      return;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_output: got result %h want no output", bus.result);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(cyc - e.acceptCyc + 1), 32'(e.lat));
    check("result", bus.result, e.res);
    check("nzcv", {28'd0, nzcv}, {28'd0, e.nzcv});
    for (int i = 0; i < hold; i++) begin
      bus.opcode   = 4'd1;
      bus.a        = 32'd1;
      bus.b        = 32'd1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("stall_result", bus.result, e.res);
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    check("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int quiet;
    //                op     a             b             result        NZCV     lat
    vecs[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1};
    vecs[1]  = '{4'd0, 32'h00000001, 32'h00000001, 32'h00000003, 4'b0000, 1};
    vecs[2]  = '{4'd3, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b1000, 1};
    vecs[3]  = '{4'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1};
    vecs[4]  = '{4'd4, 32'h00000007, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1};
    vecs[5]  = '{4'd2, 32'h0000000A, 32'h00000003, 32'h00000006, 4'b0010, 1};
    vecs[6]  = '{4'd2, 32'h00000003, 32'h00000003, 32'h00000000, 4'b0110, 1};
    vecs[7]  = '{4'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0010, 1};
    vecs[8]  = '{4'd7, 32'h80000000, 32'h00000001, 32'h80000001, 4'b1010, 1};
    vecs[9]  = '{4'd6, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 4'b0110, 1};
    vecs[10] = '{4'd0, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 4'b1001, 1};
    vecs[11] = '{4'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b1001, 1};
    vecs[12] = '{4'd8, 32'h00000003, 32'h00000003, 32'h00000000, 4'b0110, 1};
    vecs[13] = '{4'd12, 32'h00000005, 32'h00000006, 32'h00000000, 4'b0110, 1};
    vecs[14] = '{4'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1};
    vecs[15] = '{4'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1};
    vecs[16] = '{4'd5, 32'h00010000, 32'h00010001, 32'h00010000, 4'b0011, 33};
    vecs[17] = '{4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0011, 33};
    vecs[18] = '{4'd5, 32'h00000000, 32'h00000005, 32'h00000000, 4'b0111, 33};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_nzcv", {28'd0, nzcv}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].nzcv, vecs[i].lat);
      checkOutput(0);
    end

    // Backpressure: result must stay frozen and no new op accepted while stalled.
    applyStimulus(4'd7, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0011, 1);
    checkOutput(5);

    // Reset ten cycles into a multiply: the op vanishes without output.
    applyStimulus(4'd5, 32'h00000003, 32'h00000005, 32'h0000000F, 4'b0011, 33);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_nzcv", {28'd0, nzcv}, 32'd0);
    check("abort_in_ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.delete();
    quiet = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) quiet = 0;
    end
    check("abort_no_output", 32'(quiet), 32'd1);

    applyStimulus(4'd0, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 1);
    checkOutput(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
